// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60Hz raster constants and coordinate type shared by the timing generator and renderers
package vga_timing_pkg;
    typedef logic [9:0] coord_t;
    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: modulo-N counter with enable, wrap flag and synchronous reset
// Ports: vga_clk, reset (sync, active-high), en (advance), count (register),
//        next (value count takes on the next edge, ignoring reset), wrap (count leaves N-1 this cycle)
module vga_wrap_counter import vga_timing_pkg::*; #(
    parameter coord_t N = H_TOTAL
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   en,
    output coord_t count,
    output coord_t next,
    output logic   wrap
);
    assign wrap = en && count == N - 10'd1;
    assign next = wrap ? '0 : en ? count + 10'd1 : count;
    always_ff @(posedge vga_clk) begin
        if (reset) count <= '0;
        else count <= next;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA sync, blank and pixel coordinate generator
// Ports: vga_clk, reset (sync, active-high), hs/vs (active-low syncs), blank (1 = visible),
//        sync (tied 0), DrawX/DrawY (current position), frame_start (pulse at (0,0)),
//        frame_count (frames since reset, only when VGA_FRAME_COUNT_EN is defined)
// Decodes are taken from the counters' next values and registered, so every output
// describes the same pixel as DrawX/DrawY on the same cycle.
module vga_timing_gen import vga_timing_pkg::*; (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    coord_t h_next, v_next;
    logic h_wrap, v_wrap;
    vga_wrap_counter #(.N(H_TOTAL)) u_h (
        .vga_clk(vga_clk), .reset(reset), .en(1'b1),
        .count(DrawX), .next(h_next), .wrap(h_wrap)
    );
    vga_wrap_counter #(.N(V_TOTAL)) u_v (
        .vga_clk(vga_clk), .reset(reset), .en(h_wrap),
        .count(DrawY), .next(v_next), .wrap(v_wrap)
    );
    assign sync = 1'b0;
    // v_wrap fires only when both counters roll over together, i.e. next position is (0,0)
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hs          <= !(h_next >= H_VISIBLE + H_FP && h_next < H_VISIBLE + H_FP + H_SYNC);
            vs          <= !(v_next >= V_VISIBLE + V_FP && v_next < V_VISIBLE + V_FP + V_SYNC);
            blank       <= h_next < H_VISIBLE && v_next < V_VISIBLE;
            frame_start <= v_wrap;
        end
    end
`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge vga_clk) begin
        if (reset) frame_count <= '0;
        else if (v_wrap) frame_count <= frame_count + 16'd1;
    end
`endif
endmodule
